// File: rtl/result_bus_arbiter_pkg.sv
// processor_pkg: shared result-bus types, widths and requester indices
package processor_pkg;
    typedef enum logic {EMPTY, FULL} state_t;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int REQ_ALU = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_MUL = 2;
    localparam int REQ_LINK = 3;
endpackage

// File: rtl/result_bus_arbiter_if.sv
// result_bus_arbiter_if: requester-side and consumer-side handshakes of the result bus
interface result_bus_arbiter_if
    import processor_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int SEL_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [SEL_WIDTH-1:0] out_sel;
    logic out_ready;
    modport master (
        input req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );
    modport slave (
        output req_valid, req_data, out_ready,
        input req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/result_bus_arbiter_rr_priority_pick.sv
// rr_priority_pick: round-robin search for the first request after index last
module rr_priority_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input logic [N-1:0] req,
    input logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic any
);
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last) + k) % N]) begin
                any = 1'b1;
                idx = W'((int'(last) + k) % N);
                grant[(int'(last) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin arbiter sharing the result bus through a one-word output register
module result_bus_arbiter
    import processor_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ = 4,
    localparam int SEL_WIDTH = $clog2(NUM_REQ)
) (
    input logic clk,
    input logic reset_n,
    result_bus_arbiter_if.master bus
);
    state_t state;
    logic [SEL_WIDTH-1:0] last, win, out_sel;
    logic [NUM_REQ-1:0] grant;
    logic any, load, out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    rr_priority_pick #(.N(NUM_REQ)) pick (
        .req(bus.req_valid),
        .last(last),
        .grant(grant),
        .idx(win),
        .any(any)
    );

    assign load = state == EMPTY || (bus.out_ready && out_valid);
    assign bus.req_ready = load && reset_n ? grant : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_data = out_data;
    assign bus.out_sel = out_sel;

    // a drain with no winner empties the register; data and sel are left as they were
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            last <= SEL_WIDTH'(NUM_REQ - 1);
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
        end else if (load) begin
            if (any) begin
                state <= FULL;
                out_valid <= 1'b1;
                out_data <= bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                out_sel <= win;
                last <= win;
            end else begin
                state <= EMPTY;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: directed and random checks of the result-bus arbiter
module tb_result_bus_arbiter;
    import processor_pkg::*;

    typedef struct packed {
        logic [1:0] sel;
        logic [15:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset_n;
    int passed = 0;
    int total = 0;
    word_t q[$];
    word_t w;
    int wt[4];
    logic [3:0] acc;
    logic draining;
    int cnt = 0;
    logic [3:0] pv = '0, pr = '0;
    logic [63:0] pd = '0;
    logic pov = 1'b0, por = 1'b0;

    result_bus_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

    result_bus_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // requesters must hold pending words; the arbiter must hold an unaccepted output
    always @(negedge clk) begin
        if (!reset_n) begin
            pv <= '0;
            pov <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (pv[i] && !pr[i])
                    chk("req_hold", {31'd0, bus.req_valid[i] && bus.req_data[i*16 +: 16] == pd[i*16 +: 16]}, 1);
            if (pov && !por) chk("out_hold", {31'd0, bus.out_valid}, 1);
            pv <= bus.req_valid;
            pr <= bus.req_ready;
            pd <= bus.req_data;
            pov <= bus.out_valid;
            por <= bus.out_ready;
        end
    end

    initial begin
        reset_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.out_ready = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_data", {16'd0, bus.out_data}, 0);
        chk("rst_sel", {30'd0, bus.out_sel}, 0);
        chk("rst_ready", {28'd0, bus.req_ready}, 0);
        #6 reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.req_valid = i < 4 ? 4'hF : 4'((8'hF << (i - 4)) & 8'hF);
            #1;
            chk("rr_ready", {28'd0, bus.req_ready}, 32'd1 << (i % 4));
            tick();
            chk("rr_valid", {31'd0, bus.out_valid}, 1);
            chk("rr_sel", {30'd0, bus.out_sel}, 32'(i % 4));
            chk("rr_data", {16'd0, bus.out_data}, 32'h1111 * 32'(i % 4 + 1));
        end

        bus.req_valid = 4'b0100;
        bus.req_data[REQ_MUL*16 +: 16] = 16'hABCD;
        #1;
        chk("mul_ready", {28'd0, bus.req_ready}, 32'b0100);
        tick();
        chk("mul_data", {16'd0, bus.out_data}, 32'hABCD);
        chk("mul_sel", {30'd0, bus.out_sel}, 2);
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", {28'd0, bus.req_ready}, 0);
            tick();
            chk("bp_valid", {31'd0, bus.out_valid}, 1);
            chk("bp_data", {16'd0, bus.out_data}, 32'hABCD);
            chk("bp_sel", {30'd0, bus.out_sel}, 2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("wrap_ready", {28'd0, bus.req_ready}, 32'b0001);
        tick();
        chk("wrap_sel", {30'd0, bus.out_sel}, 0);
        chk("wrap_data", {16'd0, bus.out_data}, 32'h1111);
        bus.req_valid = 4'b0010;
        #1;
        chk("load_ready", {28'd0, bus.req_ready}, 32'b0010);
        tick();
        chk("load_sel", {30'd0, bus.out_sel}, 1);

        bus.req_data[REQ_LOAD*16 +: 16] = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("single_ready", {28'd0, bus.req_ready}, 32'b0010);
            tick();
            chk("single_valid", {31'd0, bus.out_valid}, 1);
            chk("single_sel", {30'd0, bus.out_sel}, 1);
            chk("single_data", {16'd0, bus.out_data}, 32'h00FF);
        end

        bus.req_valid = 4'b0000;
        #1;
        chk("drain_ready", {28'd0, bus.req_ready}, 0);
        tick();
        chk("drain_valid", {31'd0, bus.out_valid}, 0);
        tick();
        chk("idle_valid", {31'd0, bus.out_valid}, 0);
        bus.req_valid = 4'b1000;
        bus.req_data[REQ_LINK*16 +: 16] = 16'h5A5A;
        #1;
        chk("lat_ready", {28'd0, bus.req_ready}, 32'b1000);
        tick();
        chk("lat_valid", {31'd0, bus.out_valid}, 1);
        chk("lat_data", {16'd0, bus.out_data}, 32'h5A5A);
        chk("lat_sel", {30'd0, bus.out_sel}, 3);

        bus.req_valid = 4'b0000;
        bus.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 0);
        chk("arst_data", {16'd0, bus.out_data}, 0);
        chk("arst_sel", {30'd0, bus.out_sel}, 0);
        chk("arst_ready", {28'd0, bus.req_ready}, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("post_ready", {28'd0, bus.req_ready}, 32'b0001);
        tick();
        chk("post_sel", {30'd0, bus.out_sel}, 0);
        chk("post_data", {16'd0, bus.out_data}, 32'h1111);

        // the word already in the output register and the three still-waiting requesters seed the scoreboard
        q.push_back('{sel: 2'd0, data: 16'h1111});
        wt = '{0, 1, 1, 1};
        acc = 4'b0001;
        for (int c = 0; c < 10100; c++) begin
            draining = c >= 10000;
            if (draining && q.size() == 0 && bus.req_valid == 0 && !bus.out_valid) break;
            for (int j = 0; j < 4; j++)
                if (acc[j] || !bus.req_valid[j]) begin
                    bus.req_valid[j] = !draining && $urandom_range(99) < 55;
                    bus.req_data[j*16 +: 16] = {2'(j), 14'(cnt)};
                    cnt++;
                end
            bus.out_ready = draining || $urandom_range(3) != 0;
            @(negedge clk);
            chk("onehot", {31'd0, $onehot0(bus.req_ready) && (bus.req_ready & ~bus.req_valid) == 0}, 1);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("sb_dup", 1, 0);
                else begin
                    w = q.pop_front();
                    chk("sb_data", {16'd0, bus.out_data}, {16'd0, w.data});
                    chk("sb_sel", {30'd0, bus.out_sel}, {30'd0, w.sel});
                end
            end
            acc = bus.req_valid & bus.req_ready;
            if (acc != 0)
                for (int j = 0; j < 4; j++) begin
                    if (acc[j]) begin
                        q.push_back('{sel: 2'(j), data: bus.req_data[j*16 +: 16]});
                        wt[j] = 0;
                    end else if (bus.req_valid[j]) begin
                        wt[j]++;
                        chk("fair", 32'(wt[j] <= 3), 1);
                    end
                end
            @(posedge clk);
            #1;
        end
        chk("drained", {31'd0, q.size() == 0 && !bus.out_valid}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
